// File: rtl/bus_bridge_dispatch_if.sv
// bus_bridge_dispatch_if: CPU request/response and data-side target signals of the load/store dispatcher
interface bus_bridge_dispatch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  tgt_sel;
  logic [31:0] tgt_addr;
  logic        tgt_we;
  logic [3:0]  tgt_byteen;
  logic [31:0] tgt_wdata;
  logic [3:0]  tgt_ack;
  logic [31:0] tgt_rdata_dm;
  logic [31:0] tgt_rdata_t0;
  logic [31:0] tgt_rdata_t1;
  logic [31:0] tgt_rdata_ig;
  modport slave (
    input  req_valid, req_addr, req_we, req_byteen, req_wdata,
    input  tgt_ack, tgt_rdata_dm, tgt_rdata_t0, tgt_rdata_t1, tgt_rdata_ig,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output tgt_sel, tgt_addr, tgt_we, tgt_byteen, tgt_wdata
  );
  modport master (
    output req_valid, req_addr, req_we, req_byteen, req_wdata,
    output tgt_ack, tgt_rdata_dm, tgt_rdata_t0, tgt_rdata_t1, tgt_rdata_ig,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  tgt_sel, tgt_addr, tgt_we, tgt_byteen, tgt_wdata
  );
endinterface

// File: rtl/bus_bridge_dispatch.sv
// bus_bridge_dispatch: decodes CPU loads/stores onto DM/Timer0/Timer1/IG and returns one response beat
module bus_bridge_dispatch #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] DM_LIMIT = 32'h0000_2FFF,
  parameter logic [31:0] T0_BASE  = 32'h0000_7F00,
  parameter logic [31:0] T1_BASE  = 32'h0000_7F10,
  parameter logic [31:0] IG_BASE  = 32'h0000_7F20
) (
  input logic                  clk,
  input logic                  reset,
  bus_bridge_dispatch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [3:0]  r_sel, r_byteen, w_sel;
  logic [31:0] r_addr, r_wdata, r_rdata, w_rdata;
  logic        r_we, r_err, w_hs, w_word, w_dm_ok, w_err, w_ack, w_tmo;
  logic [1:0]  w_off;
  assign w_off    = bus.req_addr[1:0];
  assign w_sel[0] = bus.req_addr <= DM_LIMIT;
  assign w_sel[1] = bus.req_addr >= T0_BASE && bus.req_addr <= T0_BASE + 32'd11;
  assign w_sel[2] = bus.req_addr >= T1_BASE && bus.req_addr <= T1_BASE + 32'd11;
  assign w_sel[3] = bus.req_addr >= IG_BASE && bus.req_addr <= IG_BASE + 32'd3;
  assign w_word   = bus.req_byteen == 4'hf && w_off == 2'd0;
  // DM lanes must be naturally aligned: word at 0, halfword at 0/2, byte at its own offset
  assign w_dm_ok  = w_word || (bus.req_byteen == 4'h3 && w_off == 2'd0) ||
                    (bus.req_byteen == 4'hc && w_off == 2'd2) || bus.req_byteen == 4'(4'b0001 << w_off);
  assign w_err    = bus.req_byteen == 4'h0 || w_sel == 4'h0 ||
                    (|w_sel[3:1] && !w_word) || (w_sel[0] && !w_dm_ok);
  assign w_hs     = bus.req_valid && r_state == IDLE;
  assign w_ack    = |(bus.tgt_ack & r_sel);
  assign w_tmo    = r_cnt == 8'(TIMEOUT - 1);
  assign w_rdata  = r_sel[0] ? bus.tgt_rdata_dm : r_sel[1] ? bus.tgt_rdata_t0 :
                    r_sel[2] ? bus.tgt_rdata_t1 : bus.tgt_rdata_ig;
  assign bus.req_ready  = r_state == IDLE;
  assign bus.resp_valid = r_state == RESP || r_state == ERR;
  assign bus.resp_err   = r_err;
  assign bus.resp_rdata = r_rdata;
  assign bus.tgt_sel    = r_state == BUSY ? r_sel : 4'b0;
  assign bus.tgt_addr   = r_addr;
  assign bus.tgt_we     = r_we && r_state == BUSY;
  assign bus.tgt_byteen = r_byteen;
  assign bus.tgt_wdata  = r_wdata;
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = w_hs ? (w_err ? ERR : BUSY) : IDLE;
    else if (r_state == BUSY) w_next = (w_ack || w_tmo) ? RESP : BUSY;
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_cnt    <= '0;
      r_sel    <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_byteen <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_hs) begin
        r_cnt    <= '0;
        r_sel    <= w_sel;
        r_addr   <= bus.req_addr;
        r_we     <= bus.req_we;
        r_byteen <= bus.req_byteen;
        r_wdata  <= bus.req_wdata;
        if (w_err) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
      if (r_state == BUSY) begin
        if (w_ack) begin
          r_rdata <= r_we ? 32'h0 : w_rdata;
          r_err   <= 1'b0;
        end else if (w_tmo) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end else r_cnt <= r_cnt + 8'd1;
      end
    end
endmodule

// File: tb/tb_bus_bridge_dispatch.sv
// tb_bus_bridge_dispatch: directed and randomized checks of the dispatcher against an address-map model
module tb_bus_bridge_dispatch;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  bus_bridge_dispatch_if bus();
  bus_bridge_dispatch #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_checks = 0;
  int n_fail = 0;
  int o_lat, o_selcyc;
  logic o_err, o_ready, o_stable, o_multi, o_we;
  logic [31:0] o_rdata, o_hold, o_addr, o_wdata;
  logic [3:0] o_selor, o_be;

  function automatic int region(input logic [31:0] a);
    if (a <= 32'h2FFF) return 0;
    if (a >= 32'h7F00 && a < 32'h7F00 + 12) return 1;
    if (a >= 32'h7F10 && a < 32'h7F10 + 12) return 2;
    if (a >= 32'h7F20 && a < 32'h7F20 + 4) return 3;
    return -1;
  endfunction

  function automatic bit legal(input logic [31:0] a, input logic [3:0] be);
    int r = region(a);
    int n = $countones(be);
    int off = int'(a[1:0]);
    if (r < 0 || be == 4'h0) return 0;
    if (r > 0) return be == 4'hf && off == 0;
    if (!(n == 1 || n == 2 || n == 4) || off % n != 0) return 0;
    return be == 4'(((1 << n) - 1) << off);
  endfunction

  task automatic txn(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd,
                     input int delay, input logic [31:0] rd, input logic [3:0] stray, input int stray_at);
    int r = region(a);
    logic [3:0] m = r < 0 ? 4'b0 : 4'(1 << r);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_we = we; bus.req_byteen = be; bus.req_wdata = wd;
    bus.tgt_rdata_dm = m[0] ? rd : ~rd;
    bus.tgt_rdata_t0 = m[1] ? rd : ~rd;
    bus.tgt_rdata_t1 = m[2] ? rd : ~rd;
    bus.tgt_rdata_ig = m[3] ? rd : ~rd;
    o_lat = 0; o_selcyc = 0; o_selor = 4'b0; o_stable = 1'b1; o_multi = 1'b0;
    o_err = 1'bx; o_rdata = 'x; o_addr = 'x; o_wdata = 'x; o_we = 1'bx; o_be = 'x;
    for (int j = 1; j <= 40 && o_lat == 0; j++) begin
      @(negedge clk);
      bus.req_valid = 1'b0; bus.req_addr = $urandom(); bus.req_wdata = $urandom(); bus.req_byteen = 4'($urandom());
      if (bus.tgt_sel != 4'b0) begin
        if (o_selcyc == 0) begin
          o_addr = bus.tgt_addr; o_wdata = bus.tgt_wdata; o_we = bus.tgt_we; o_be = bus.tgt_byteen;
        end else if ({bus.tgt_addr, bus.tgt_wdata, bus.tgt_we, bus.tgt_byteen} !== {o_addr, o_wdata, o_we, o_be})
          o_stable = 1'b0;
        o_selcyc++;
      end
      if (!$onehot0(bus.tgt_sel)) o_multi = 1'b1;
      o_selor |= bus.tgt_sel;
      if (bus.resp_valid) begin
        o_lat = j; o_err = bus.resp_err; o_rdata = bus.resp_rdata;
      end
      bus.tgt_ack = (j == delay + 1 ? m : 4'b0) | (j == stray_at ? stray : 4'b0);
    end
    bus.tgt_ack = 4'b0;
    @(negedge clk);
    o_ready = bus.req_ready && !bus.resp_valid;
    o_hold = bus.resp_rdata;
  endtask

  task automatic test_reset;
    bus.req_valid = 1'b1; bus.req_addr = 32'h0; bus.req_we = 1'b0; bus.req_byteen = 4'hf;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", bus.req_ready); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b expected 0", bus.resp_valid); end
    n_checks++; if (bus.tgt_sel !== 4'b0) begin n_fail++; $display("FAIL rst_tgt_sel: got %b expected 0000", bus.tgt_sel); end
    n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b expected 0", bus.resp_err); end
    n_checks++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", bus.resp_rdata); end
    reset = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.tgt_sel !== 4'b0 || bus.req_ready !== 1'b1)
      begin n_fail++; $display("FAIL rst_no_accept: got sel=%b ready=%b expected sel=0000 ready=1", bus.tgt_sel, bus.req_ready); end
  endtask

  task automatic test_reset_busy;
    logic seen = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'h10; bus.req_we = 1'b0; bus.req_byteen = 4'hf; bus.tgt_ack = 4'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_checks++; if (bus.tgt_sel !== 4'b0001) begin n_fail++; $display("FAIL rstbusy_sel: got %b expected 0001", bus.tgt_sel); end
    repeat (3) begin
      @(negedge clk);
      seen |= bus.resp_valid;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen |= bus.resp_valid;
    n_checks++; if (bus.req_ready !== 1'b1 || bus.tgt_sel !== 4'b0)
      begin n_fail++; $display("FAIL rstbusy_idle: got ready=%b sel=%b expected ready=1 sel=0000", bus.req_ready, bus.tgt_sel); end
    @(negedge clk);
    seen |= bus.resp_valid;
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstbusy_no_resp: got resp_valid seen=%b expected 0", seen); end
  endtask

  task automatic test_dm_load;
    txn(32'h100, 1'b0, 4'hf, 32'h0, 0, 32'hDEAD_BEEF, 4'b0, 0);
    n_checks++; if (o_lat !== 2) begin n_fail++; $display("FAIL dm_lat: got %0d expected 2", o_lat); end
    n_checks++; if (o_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dm_rdata: got %h expected deadbeef", o_rdata); end
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL dm_err: got %b expected 0", o_err); end
    n_checks++; if (o_selor !== 4'b0001 || o_selcyc !== 1)
      begin n_fail++; $display("FAIL dm_sel: got %b x%0d expected 0001 x1", o_selor, o_selcyc); end
    n_checks++; if (o_hold !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dm_hold: got %h expected deadbeef", o_hold); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL dm_ready: got %b expected 1", o_ready); end
  endtask

  task automatic test_t0_store;
    txn(32'h7F04, 1'b1, 4'hf, 32'h9, 3, 32'h55AA_55AA, 4'b0, 0);
    n_checks++; if (o_lat !== 5) begin n_fail++; $display("FAIL t0_lat: got %0d expected 5", o_lat); end
    n_checks++; if (o_selor !== 4'b0010 || o_selcyc !== 4)
      begin n_fail++; $display("FAIL t0_sel: got %b x%0d expected 0010 x4", o_selor, o_selcyc); end
    n_checks++; if (o_wdata !== 32'h9 || o_we !== 1'b1 || o_addr !== 32'h7F04)
      begin n_fail++; $display("FAIL t0_fields: got wdata=%h we=%b addr=%h expected 9 1 7f04", o_wdata, o_we, o_addr); end
    n_checks++; if (o_stable !== 1'b1) begin n_fail++; $display("FAIL t0_stable: got %b expected 1", o_stable); end
    n_checks++; if (o_rdata !== 32'h0 || o_err !== 1'b0)
      begin n_fail++; $display("FAIL t0_resp: got rdata=%h err=%b expected 0 0", o_rdata, o_err); end
  endtask

  task automatic test_illegal;
    logic [31:0] ia [3] = '{32'h7F10, 32'h5000, 32'h0};
    logic [3:0]  ib [3] = '{4'b0010, 4'hf, 4'b0110};
    logic        iw [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      txn(ia[i], iw[i], ib[i], 32'h1234, 0, 32'hCAFE_F00D, 4'b0, 0);
      n_checks++; if (o_lat !== 1 || o_err !== 1'b1)
        begin n_fail++; $display("FAIL illegal%0d_resp: got lat=%0d err=%b expected 1 1", i, o_lat, o_err); end
      n_checks++; if (o_selor !== 4'b0 || o_rdata !== 32'h0)
        begin n_fail++; $display("FAIL illegal%0d_sel: got sel=%b rdata=%h expected 0000 0", i, o_selor, o_rdata); end
    end
  endtask

  task automatic test_timeout;
    txn(32'h7F20, 1'b0, 4'hf, 32'h0, 1000, 32'h1111_2222, 4'b0001, 5);
    n_checks++; if (o_lat !== TIMEOUT + 1) begin n_fail++; $display("FAIL tmo_lat: got %0d expected %0d", o_lat, TIMEOUT + 1); end
    n_checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0)
      begin n_fail++; $display("FAIL tmo_resp: got err=%b rdata=%h expected 1 0", o_err, o_rdata); end
    n_checks++; if (o_selor !== 4'b1000 || o_selcyc !== TIMEOUT)
      begin n_fail++; $display("FAIL tmo_sel: got %b x%0d expected 1000 x%0d", o_selor, o_selcyc, TIMEOUT); end
  endtask

  task automatic test_back_to_back;
    int hs[$];
    int rs[$];
    logic [31:0] rv[$];
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'h0; bus.req_we = 1'b0; bus.req_byteen = 4'hf;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (hs.size() == 1) bus.req_addr = 32'h4;
      if (hs.size() == 2) bus.req_valid = 1'b0;
      if (bus.req_valid && bus.req_ready) hs.push_back(c);
      if (bus.resp_valid) begin rs.push_back(c); rv.push_back(bus.resp_rdata); end
      bus.tgt_ack = bus.tgt_sel;
      bus.tgt_rdata_dm = 32'hB0B0_0000 | bus.tgt_addr;
    end
    bus.tgt_ack = 4'b0; bus.req_valid = 1'b0;
    n_checks++; if (hs.size() !== 2 || rs.size() !== 2)
      begin n_fail++; $display("FAIL b2b_count: got hs=%0d resp=%0d expected 2 2", hs.size(), rs.size()); end
    if (hs.size() >= 2 && rs.size() >= 2) begin
      n_checks++; if (hs[1] - hs[0] !== 3) begin n_fail++; $display("FAIL b2b_hs_gap: got %0d expected 3", hs[1] - hs[0]); end
      n_checks++; if (rs[0] - hs[0] !== 2 || rs[1] - hs[0] !== 5)
        begin n_fail++; $display("FAIL b2b_resp_time: got %0d,%0d expected 2,5", rs[0] - hs[0], rs[1] - hs[0]); end
      n_checks++; if (rv[0] !== 32'hB0B0_0000 || rv[1] !== 32'hB0B0_0004)
        begin n_fail++; $display("FAIL b2b_rdata: got %h,%h expected b0b00000,b0b00004", rv[0], rv[1]); end
    end
  endtask

  task automatic test_random;
    logic [31:0] pool [12] = '{32'h2FFC, 32'h3000, 32'h7EFC, 32'h7F00, 32'h7F08, 32'h7F0C,
                               32'h7F10, 32'h7F18, 32'h7F1C, 32'h7F20, 32'h7F24, 32'h5000};
    logic [3:0] bp [8] = '{4'hf, 4'h3, 4'hc, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6};
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, wd, rd, e_rd;
      logic [3:0] be, e_sel;
      logic we, e_err;
      int delay, e_lat, e_cyc, r;
      a = $urandom_range(0, 3) == 0 ? pool[$urandom_range(0, 11)] + $urandom_range(0, 3) : $urandom_range(0, 32'h2FFF);
      be = $urandom_range(0, 4) == 0 ? 4'($urandom()) : bp[$urandom_range(0, 7)];
      we = 1'($urandom_range(0, 1)); wd = $urandom(); rd = $urandom(); delay = $urandom_range(0, 18);
      r = region(a);
      if (!legal(a, be)) begin e_lat = 1; e_err = 1'b1; e_rd = 32'h0; e_sel = 4'b0; e_cyc = 0; end
      else if (delay < TIMEOUT) begin e_lat = delay + 2; e_err = 1'b0; e_rd = we ? 32'h0 : rd; e_sel = 4'(1 << r); e_cyc = delay + 1; end
      else begin e_lat = TIMEOUT + 1; e_err = 1'b1; e_rd = 32'h0; e_sel = 4'(1 << r); e_cyc = TIMEOUT; end
      txn(a, we, be, wd, delay, rd, 4'($urandom()) & ~(r < 0 ? 4'b0 : 4'(1 << r)), $urandom_range(1, 20));
      n_checks++; if (o_lat !== e_lat || o_err !== e_err)
        begin n_fail++; $display("FAIL rnd%0d_resp a=%h be=%b: got lat=%0d err=%b expected %0d %b", i, a, be, o_lat, o_err, e_lat, e_err); end
      n_checks++; if (o_rdata !== e_rd || o_hold !== e_rd)
        begin n_fail++; $display("FAIL rnd%0d_rdata: got %h hold %h expected %h", i, o_rdata, o_hold, e_rd); end
      n_checks++; if (o_selor !== e_sel || o_selcyc !== e_cyc || o_multi !== 1'b0)
        begin n_fail++; $display("FAIL rnd%0d_sel: got %b x%0d expected %b x%0d", i, o_selor, o_selcyc, e_sel, e_cyc); end
      n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_ready: got %b expected 1", i, o_ready); end
      if (e_cyc > 0) begin
        n_checks++; if (o_addr !== a || o_we !== we || o_be !== be || o_wdata !== wd || o_stable !== 1'b1)
          begin n_fail++; $display("FAIL rnd%0d_fields: got %h %b %b %h st=%b expected %h %b %b %h", i, o_addr, o_we, o_be, o_wdata, o_stable, a, we, be, wd); end
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_we = 1'b0; bus.req_byteen = '0; bus.req_wdata = '0;
    bus.tgt_ack = '0; bus.tgt_rdata_dm = '0; bus.tgt_rdata_t0 = '0; bus.tgt_rdata_t1 = '0; bus.tgt_rdata_ig = '0;
    test_reset;
    test_reset_busy;
    test_dm_load;
    test_t0_store;
    test_illegal;
    test_timeout;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion within 50000 cycles");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/bus_bridge_dispatch.md
Name: bus_bridge_dispatch

Overview:
- Load/store dispatcher between the CPU memory stage and the data-side slaves: DM, Timer0, Timer1 and the interrupt generator.
- Accepts one request at a time, decodes the address, and drives exactly one one-hot target select.
- Waits for that target's ack with a timeout, registers the read data, and returns one response beat.
- Flags illegal or unmapped accesses with an error response so the CP0 path can raise AdEL/AdES.

Parameters:
- TIMEOUT, 16: max BUSY cycles without ack before an error response; range 1..255.
- DM_LIMIT, 32'h0000_2FFF: last byte address of DM; DM spans 0..DM_LIMIT.
- T0_BASE, 32'h0000_7F00: Timer0 base; 3 words, T0_BASE..T0_BASE+11.
- T1_BASE, 32'h0000_7F10: Timer1 base; 3 words.
- IG_BASE, 32'h0000_7F20: interrupt generator; 1 word.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_byteen  in  4  byte enables.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_err  out  1  with resp_valid: access faulted.
- resp_rdata  out  32  load data; 0 for stores and errors.
- tgt_sel  out  4  one-hot: bit0 DM, bit1 T0, bit2 T1, bit3 IG.
- tgt_addr  out  32  latched address.
- tgt_we  out  1  latched write enable, gated by the selected target.
- tgt_byteen  out  4  latched byte enables.
- tgt_wdata  out  32  latched write data.
- tgt_ack  in  4  per-target completion, same bit order as tgt_sel.
- tgt_rdata_dm, tgt_rdata_t0, tgt_rdata_t1, tgt_rdata_ig  in  32 each  target read data, valid while that target's ack is high.

Behaviour:
- States are IDLE, BUSY, RESP and ERR.
- Reset, synchronous and dominant:
  - state = IDLE, timeout counter = 0.
  - All registered request fields, resp_rdata and resp_err are 0.
  - tgt_sel = 0 and resp_valid = 0.
  - A request presented in the reset cycle is not accepted.
  - Reset in BUSY abandons the transaction with no response.
- req_ready = (state == IDLE). A handshake occurs when req_valid && req_ready.
- Decode is done at acceptance and the selected target index is latched. Fields are latched: addr, we, byteen, wdata.
- Error conditions:
  - req_byteen == 0.
  - Address in no region.
  - Address in T0/T1/IG with req_byteen != 4'b1111 or addr[1:0] != 0. Timers and IG accept word access only.
  - Address in DM with byteen not aligned to addr[1:0]. Legal patterns are 1111 at offset 0; 0011/1100 at offsets 0/2; a single bit matching addr[1:0].
- On a handshake, the next state is:
  - ERR if any error condition holds.
  - BUSY otherwise, with counter = 0.
- BUSY:
  - tgt_sel = latched one-hot. tgt_addr, tgt_we, tgt_byteen and tgt_wdata are stable for the whole state.
  - Only the ack bit of the selected target counts; the other ack bits are ignored.
  - On ack, capture the selected rdata into resp_rdata (0 if store), set resp_err = 0, go to RESP.
  - Otherwise the counter increments. When counter == TIMEOUT-1 without ack: resp_rdata = 0, resp_err = 1, go to RESP.
- RESP: resp_valid = 1 for exactly one cycle, tgt_sel = 0, then IDLE.
- ERR: resp_valid = 1 and resp_err = 1 for one cycle, resp_rdata = 0, then IDLE. No tgt_sel is ever asserted for an errored request.
- resp_rdata and resp_err hold their values until the next response.
- Latency:
  - Handshake at cycle T, target ack at T+k with k ≥ 1: resp_valid at T+k+1.
  - Zero-wait target (ack in the first BUSY cycle): response at T+2.
  - Error: response at T+1.
- Throughput: the next request is accepted in the cycle after resp_valid, so a new handshake can occur no earlier than T+k+2.
- tgt_sel is never more than one-hot, and it is 0 outside BUSY.

Test Plan:
- Reset mid-BUSY:
  - Stimulus: load 0x0000_0010, hold all ack low for 3 cycles, then assert reset 1 cycle.
  - Required: no resp_valid; next cycle req_ready = 1, tgt_sel = 0.
- DM word load:
  - Stimulus: addr 0x0000_0100, byteen 1111, we = 0; DM acks in the first BUSY cycle with rdata 0xDEADBEEF.
  - Required: tgt_sel = 0001 at T+1; resp_valid at T+2 with rdata 0xDEADBEEF, err = 0.
- Timer0 store with 3 wait cycles:
  - Stimulus: addr 0x7F04, wdata 0x0000_0009, byteen 1111, we = 1; ack[1] on the 4th BUSY cycle.
  - Required: tgt_sel = 0010 for 4 cycles, tgt_wdata = 9; resp at T+5 with rdata 0, err = 0.
- Illegal accesses:
  - Stimulus: sb to 0x7F10 (byteen 0010); then load from 0x0000_5000; then byteen 0110 to 0x0000_0000.
  - Required: each gets resp_err = 1 at T+1, tgt_sel stays 0000 throughout.
- Timeout (TIMEOUT = 16):
  - Stimulus: load to IG 0x7F20, no ack; a stray ack[0] pulse during the wait.
  - Required: stray ack is ignored; after 16 BUSY cycles resp_valid with err = 1, rdata = 0.
- Back-to-back requests:
  - Stimulus: req_valid held high with two DM loads, 0x0 then 0x4, zero-wait target.
  - Required: handshakes at T and T+3; responses at T+2 and T+5.
